// File: rtl/rram_buf_pkg.sv
// Shared constants and types for the RRAM data buffer scheduler.
package rram_buf_pkg;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 6;
    localparam int DEPTH   = 2 ** ADDR_W;
    localparam int NUM_REQ = 2;
    localparam int OCC_W   = ADDR_W + 1;

    typedef enum logic {
        CLS_WR = 1'b0,
        CLS_RD = 1'b1
    } req_cls_e;

endpackage

// File: rtl/rram_buf_sched_rr_arb2.sv
// Two-way round-robin arbiter. last_q holds the index of the most recent
// contention winner; its reset value of 1 hands the first contention to
// requester 0. Uncontended grants leave the pointer alone.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       upd_en_i,
    output logic [1:0] grant_o
);

    logic last_q, last_d;

    // Grant decode and pointer next-state
    always_comb begin
        grant_o = 2'b00;
        unique case (req_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = last_q ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
        endcase
        last_d = last_q;
        if (upd_en_i && (grant_o != 2'b00)) begin
            last_d = grant_o[1];
        end
    end

    // Last-winner pointer register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/rram_buf_sched.sv
// Two-requester scheduler for the shared RRAM data buffer: one write and one
// read grant per cycle to an external dual-port RAM, per-entry valid bits,
// occupancy tracking and tagged read responses.
module rram_buf_sched
    import rram_buf_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic              req0_consume,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    input  logic              req1_consume,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp0_err,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              rsp1_err,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic [OCC_W-1:0]  occupancy,
    output logic              full,
    output logic              empty
);

    logic [NUM_REQ-1:0] wr_req, rd_req, wr_gnt, rd_gnt;
    logic               wr_any, rd_any;
    logic [ADDR_W-1:0]  wr_addr, rd_addr;
    logic [DATA_W-1:0]  wr_data;
    logic               rd_consume, rd_old_valid;
    logic               clr, same_addr, inc, dec;

    logic [DEPTH-1:0]   valid_q, valid_d;
    logic [OCC_W-1:0]   occ_q, occ_d;
    logic               rsp_vld_q, rsp_vld_d;
    logic               rsp_id_q, rsp_id_d;
    logic               rsp_err_q, rsp_err_d;

    assign wr_req = {req1_valid & req1_we,  req0_valid & req0_we};
    assign rd_req = {req1_valid & ~req1_we, req0_valid & ~req0_we};

    rr_arb2 u_wr_arb (
        .clk      (clk),
        .rst      (rst),
        .req_i    (wr_req),
        .upd_en_i (&wr_req),
        .grant_o  (wr_gnt)
    );

    rr_arb2 u_rd_arb (
        .clk      (clk),
        .rst      (rst),
        .req_i    (rd_req),
        .upd_en_i (&rd_req),
        .grant_o  (rd_gnt)
    );

    // Granted request muxing and bookkeeping terms
    always_comb begin
        wr_any       = |wr_gnt;
        rd_any       = |rd_gnt;
        wr_addr      = wr_gnt[1] ? req1_addr  : req0_addr;
        wr_data      = wr_gnt[1] ? req1_wdata : req0_wdata;
        rd_addr      = rd_gnt[1] ? req1_addr  : req0_addr;
        rd_consume   = rd_gnt[1] ? req1_consume : req0_consume;
        rd_old_valid = valid_q[rd_addr];
        clr          = rd_any & rd_consume & rd_old_valid;
        same_addr    = wr_any & rd_any & (wr_addr == rd_addr);
        inc          = wr_any & ~valid_q[wr_addr];
        // A write to the consumed entry re-validates it, so no decrement.
        dec          = clr & ~same_addr;
    end

    assign req0_ready  = wr_gnt[0] | rd_gnt[0];
    assign req1_ready  = wr_gnt[1] | rd_gnt[1];

    assign mem_wr_en   = wr_any;
    assign mem_wr_addr = wr_any ? wr_addr : '0;
    assign mem_wr_data = wr_any ? wr_data : '0;
    assign mem_rd_en   = rd_any;
    assign mem_rd_addr = rd_any ? rd_addr : '0;

    // Valid bitmap, occupancy and response next-state; set wins over clear
    always_comb begin
        valid_d = valid_q;
        if (clr) begin
            valid_d[rd_addr] = 1'b0;
        end
        if (wr_any) begin
            valid_d[wr_addr] = 1'b1;
        end
        occ_d = occ_q;
        if (inc && !dec && (occ_q != OCC_W'(DEPTH))) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (dec && !inc && (occ_q != '0)) begin
            occ_d = occ_q - OCC_W'(1);
        end
        rsp_vld_d = rd_any;
        rsp_id_d  = rd_gnt[1];
        rsp_err_d = ~rd_old_valid;
    end

    // State registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q   <= '0;
            occ_q     <= '0;
            rsp_vld_q <= 1'b0;
            rsp_id_q  <= 1'b0;
            rsp_err_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            occ_q     <= occ_d;
            rsp_vld_q <= rsp_vld_d;
            rsp_id_q  <= rsp_id_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    assign rsp0_valid = rsp_vld_q & ~rsp_id_q;
    assign rsp1_valid = rsp_vld_q &  rsp_id_q;
    assign rsp0_err   = rsp0_valid & rsp_err_q;
    assign rsp1_err   = rsp1_valid & rsp_err_q;
    assign rsp0_rdata = (rsp0_valid && !rsp_err_q) ? mem_rd_data : '0;
    assign rsp1_rdata = (rsp1_valid && !rsp_err_q) ? mem_rd_data : '0;

    assign occupancy  = occ_q;
    assign full       = (occ_q == OCC_W'(DEPTH));
    assign empty      = (occ_q == '0);

endmodule

// File: tb/tb_rram_buf_sched.sv
// Directed bench for rram_buf_sched with a behavioural dual-port RAM.
module tb_rram_buf_sched;
    import rram_buf_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              req0_valid, req0_ready, req0_we, req0_consume;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              req1_valid, req1_ready, req1_we, req1_consume;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
    logic [DATA_W-1:0] rsp0_rdata, rsp1_rdata;
    logic              mem_wr_en, mem_rd_en;
    logic [ADDR_W-1:0] mem_wr_addr, mem_rd_addr;
    logic [DATA_W-1:0] mem_wr_data, mem_rd_data;
    logic [OCC_W-1:0]  occupancy;
    logic              full, empty;

    int total = 0;
    int bad   = 0;

    logic [DATA_W-1:0] ram [DEPTH];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wr_en) ram[mem_wr_addr] <= mem_wr_data;
        if (mem_rd_en) mem_rd_data <= ram[mem_rd_addr];
    end

    rram_buf_sched dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_consume(req0_consume),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_consume(req1_consume),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .occupancy(occupancy), .full(full), .empty(empty)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, a1;
        rst = 1'b0;
        req0_valid = 0; req0_we = 0; req0_addr = '0; req0_wdata = '0; req0_consume = 0;
        req1_valid = 0; req1_we = 0; req1_addr = '0; req1_wdata = '0; req1_consume = 0;
        repeat (2) tick();

        // reset state
        chk("rst_occ", occupancy, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_rsp", {rsp0_valid, rsp1_valid, rsp0_err, rsp1_err}, 0);
        chk("rst_mem_en", {mem_wr_en, mem_rd_en}, 0);
        chk("rst_ready", {req0_ready, req1_ready}, 0);
        rst = 1'b1;
        tick();
        chk("idle_rsp", {rsp0_valid, rsp1_valid}, 0);

        // write addr 5, then read+consume it from requester 1
        req0_valid = 1; req0_we = 1; req0_addr = 5; req0_wdata = 32'hDEADBEEF;
        #1;
        chk("wr5_ready", req0_ready, 1);
        chk("wr5_en", mem_wr_en, 1);
        chk("wr5_addr", mem_wr_addr, 5);
        chk("wr5_data", mem_wr_data, 32'hDEADBEEF);
        tick();
        req0_valid = 0;
        chk("wr5_occ", occupancy, 1);
        chk("wr5_empty", empty, 0);

        req1_valid = 1; req1_we = 0; req1_addr = 5; req1_consume = 1;
        #1;
        chk("rd5_ready", {req1_ready, req0_ready}, 2'b10);
        chk("rd5_en", mem_rd_en, 1);
        chk("rd5_addr", mem_rd_addr, 5);
        tick();
        req1_valid = 0;
        chk("rd5_rsp1", rsp1_valid, 1);
        chk("rd5_rsp0", rsp0_valid, 0);
        chk("rd5_data", rsp1_rdata, 32'hDEADBEEF);
        chk("rd5_err", rsp1_err, 0);
        chk("rd5_occ", occupancy, 0);
        chk("rd5_empty", empty, 1);
        tick();
        chk("rd5_pulse", rsp1_valid, 0);

        // read of an unwritten entry with consume
        req1_valid = 1; req1_we = 0; req1_addr = 9; req1_consume = 1;
        #1;
        tick();
        req1_valid = 0;
        chk("rd9_valid", rsp1_valid, 1);
        chk("rd9_err", rsp1_err, 1);
        chk("rd9_data", rsp1_rdata, 0);
        chk("rd9_occ", occupancy, 0);

        // both requesters writing different addresses: grants alternate
        a0 = 10; a1 = 20;
        req0_valid = 1; req0_we = 1;
        req1_valid = 1; req1_we = 1;
        for (int k = 0; k < 6; k++) begin
            req0_addr = ADDR_W'(a0); req0_wdata = 32'hA000_0000 | a0;
            req1_addr = ADDR_W'(a1); req1_wdata = 32'hA000_0000 | a1;
            #1;
            chk("alt_ready0", req0_ready, (k % 2 == 0));
            chk("alt_ready1", req1_ready, (k % 2 == 1));
            chk("alt_addr", mem_wr_addr, (k % 2 == 0) ? a0 : a1);
            tick();
            if (k % 2 == 0) a0++; else a1++;
        end
        req0_valid = 0; req1_valid = 0;
        chk("alt_occ", occupancy, 6);

        // same-cycle write and read+consume of a valid entry
        req0_valid = 1; req0_we = 1; req0_addr = 3; req0_wdata = 32'h1;
        tick();
        chk("pre3_occ", occupancy, 7);
        req0_wdata = 32'h2;
        req1_valid = 1; req1_we = 0; req1_addr = 3; req1_consume = 1;
        #1;
        chk("rw3_ready", {req1_ready, req0_ready}, 2'b11);
        tick();
        req0_valid = 0; req1_valid = 0;
        chk("rw3_data", rsp1_rdata, 32'h1);
        chk("rw3_err", rsp1_err, 0);
        chk("rw3_occ", occupancy, 7);
        req0_valid = 1; req0_we = 0; req0_addr = 3; req0_consume = 0;
        tick();
        req0_valid = 0;
        chk("rd3_valid", rsp0_valid, 1);
        chk("rd3_err", rsp0_err, 0);
        chk("rd3_data", rsp0_rdata, 32'h2);

        // back-to-back reads by requester 0
        req0_valid = 1; req0_we = 0; req0_addr = 10; req0_consume = 0;
        tick();
        req0_addr = 11;
        chk("b2b_v0", rsp0_valid, 1);
        chk("b2b_d0", rsp0_rdata, 32'hA000_000A);
        tick();
        req0_valid = 0;
        chk("b2b_v1", rsp0_valid, 1);
        chk("b2b_d1", rsp0_rdata, 32'hA000_000B);

        // fill every entry; addr 63 is the last invalid one
        req0_valid = 1; req0_we = 1;
        for (int a = 0; a < DEPTH; a++) begin
            req0_addr = ADDR_W'(a); req0_wdata = 32'hB000_0000 | a;
            if (a == DEPTH - 1) begin
                chk("fill_occ63", occupancy, 63);
                chk("fill_notfull", full, 0);
            end
            tick();
        end
        chk("fill_full", full, 1);
        chk("fill_occ", occupancy, 64);
        req0_addr = 0; req0_wdata = 32'hC0;
        tick();
        req0_valid = 0;
        chk("rewr_occ", occupancy, 64);
        chk("rewr_full", full, 1);

        // both write addr 40: requester 0 wins, requester 1 retries
        req0_valid = 1; req0_we = 1; req0_addr = 40; req0_wdata = 32'h111;
        req1_valid = 1; req1_we = 1; req1_addr = 40; req1_wdata = 32'h222;
        #1;
        chk("same_rdy", {req1_ready, req0_ready}, 2'b01);
        chk("same_data0", mem_wr_data, 32'h111);
        tick();
        req0_valid = 0;
        #1;
        chk("same_rdy1", {req1_ready, req0_ready}, 2'b10);
        chk("same_data1", mem_wr_data, 32'h222);
        tick();
        req1_valid = 0;
        chk("same_occ", occupancy, 64);

        // consume at full, then confirm retried write landed
        req1_valid = 1; req1_we = 0; req1_addr = 0; req1_consume = 1;
        tick();
        req1_valid = 0;
        chk("cons_data", rsp1_rdata, 32'hC0);
        chk("cons_occ", occupancy, 63);
        chk("cons_full", full, 0);
        req0_valid = 1; req0_we = 0; req0_addr = 40; req0_consume = 0;
        tick();
        req0_valid = 0;
        chk("a40_data", rsp0_rdata, 32'h222);

        // reset while a read is granted: response discarded
        req1_valid = 1; req1_we = 0; req1_addr = 5; req1_consume = 0;
        #1;
        chk("mid_rdy", req1_ready, 1);
        rst = 1'b0;
        #1;
        req1_valid = 0;
        tick();
        rst = 1'b1;
        chk("mid_rsp_a", {rsp0_valid, rsp1_valid}, 0);
        tick();
        chk("mid_rsp_b", {rsp0_valid, rsp1_valid}, 0);
        chk("mid_occ", occupancy, 0);
        chk("mid_empty", empty, 1);
        req1_valid = 1; req1_addr = 20;
        tick();
        req1_valid = 0;
        chk("mid_bitmap", rsp1_err, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
